// File: rtl/frame_gen_pkg.sv
// Shared types and constants for the GMII test-frame generator.
// Holds the FSM encoding, framing bytes and CRC-32 parameters.
package frame_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_PAYLOAD,
        S_FCS,
        S_IFG
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam int PREAMBLE_LEN = 8;
    localparam int HDR_LEN = 14;
    localparam int FCS_LEN = 4;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // Reflected (LSB-first) byte update of the CRC-32 register.
    function automatic logic [31:0] crc32_next(
        input logic [31:0] crc,
        input logic [7:0] d
    );
        logic [31:0] c;
        logic [31:0] poly_r;
        for (int i = 0; i < 32; i++)
            poly_r[i] = CRC_POLY[31-i];
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/frame_gen_if.sv
// Request and GMII transmit bundle of the frame generator.
// master drives requests; slave is the generator side.
interface frame_gen_if;
    logic        start_sending;
    logic [15:0] segment_num;
    logic [7:0]  txid;
    logic [7:0]  aux;
    logic        busy;
    logic        tx_en;
    logic [7:0]  txd;

    modport master (
        output start_sending, segment_num, txid, aux,
        input  busy, tx_en, txd
    );

    modport slave (
        input  start_sending, segment_num, txid, aux,
        output busy, tx_en, txd
    );
endinterface

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 register (reflected, init all-ones).
// init has priority over enable; the register is not complemented.
module crc32_d8
    import frame_gen_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        init,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (!resetn)
            crc <= CRC_INIT;
        else if (init)
            crc <= CRC_INIT;
        else if (enable)
            crc <= crc32_next(crc, data);
    end

endmodule

// File: rtl/frame_gen.sv
// Ethernet test-frame generator driving a GMII transmit port.
// One frame per accepted start: preamble, header, payload, FCS, gap.
module frame_gen
    import frame_gen_pkg::*;
#(
    parameter logic [47:0] DST_MAC = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC = 48'h00_0A_35_01_02_03,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int PAYLOAD_LEN = 46,
    parameter int IFG_LEN = 12
) (
    input logic        clk125MHz,
    input logic        resetn,
    frame_gen_if.slave fg
);

    // The IDLE cycle on which the next start is taken is part of the
    // gap, so the IFG state itself lasts one cycle less than IFG_LEN.
    localparam int IFG_CYC = (IFG_LEN > 1) ? IFG_LEN - 1 : 0;

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] HDR_LAST = 16'(HDR_LEN - 1);
    localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_LEN - 1);
    localparam logic [15:0] FCS_LAST = 16'(FCS_LEN - 1);
    localparam logic [15:0] IFG_LAST =
        16'((IFG_CYC > 0) ? IFG_CYC - 1 : 0);

    localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic        load;
    logic [15:0] seg_q;
    logic [7:0]  txid_q;
    logic [7:0]  aux_q;
    logic [31:0] crc;
    logic [111:0] hdr_sh;
    logic [7:0]  txd_c;
    logic        tx_en_c;
    logic        crc_en;

    always_ff @(posedge clk125MHz) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            seg_q  <= '0;
            txid_q <= '0;
            aux_q  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (load) begin
                seg_q  <= fg.segment_num;
                txid_q <= fg.txid;
                aux_q  <= fg.aux;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 16'd1;
        load    = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (fg.start_sending) begin
                    state_d = S_PREAMBLE;
                    load    = 1'b1;
                end
            end
            S_PREAMBLE: begin
                if (cnt == PRE_LAST) begin
                    state_d = S_HEADER;
                    cnt_d   = '0;
                end
            end
            S_HEADER: begin
                if (cnt == HDR_LAST) begin
                    state_d = S_PAYLOAD;
                    cnt_d   = '0;
                end
            end
            S_PAYLOAD: begin
                if (cnt == PAY_LAST) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
                end
            end
            S_FCS: begin
                if (cnt == FCS_LAST) begin
                    state_d = (IFG_CYC > 0) ? S_IFG : S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        txd_c   = 8'h00;
        tx_en_c = 1'b0;
        crc_en  = 1'b0;
        hdr_sh  = HDR << {cnt[3:0], 3'b000};
        unique case (state)
            S_PREAMBLE: begin
                tx_en_c = 1'b1;
                txd_c = (cnt == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
            end
            S_HEADER: begin
                tx_en_c = 1'b1;
                crc_en  = 1'b1;
                txd_c   = hdr_sh[111:104];
            end
            S_PAYLOAD: begin
                tx_en_c = 1'b1;
                crc_en  = 1'b1;
                if (cnt == 16'd0)
                    txd_c = txid_q;
                else if (cnt == 16'd1)
                    txd_c = seg_q[15:8];
                else if (cnt == 16'd2)
                    txd_c = seg_q[7:0];
                else if (cnt == 16'd3)
                    txd_c = aux_q;
                else
                    txd_c = cnt[7:0] - 8'd4;
            end
            S_FCS: begin
                tx_en_c = 1'b1;
                if (cnt[1:0] == 2'd0)
                    txd_c = ~crc[7:0];
                else if (cnt[1:0] == 2'd1)
                    txd_c = ~crc[15:8];
                else if (cnt[1:0] == 2'd2)
                    txd_c = ~crc[23:16];
                else
                    txd_c = ~crc[31:24];
            end
            default: ;
        endcase
    end

    crc32_d8 u_crc (
        .clk    (clk125MHz),
        .resetn (resetn),
        .init   (load),
        .enable (crc_en),
        .data   (txd_c),
        .crc    (crc)
    );

    assign fg.busy  = (state != S_IDLE);
    assign fg.tx_en = tx_en_c;
    assign fg.txd   = txd_c;

endmodule

// File: tb/tb_frame_gen.sv
// Scoreboard bench for frame_gen: a frame model feeds per-DUT queues,
// a negedge monitor pops and compares every transmitted byte.
module tb_frame_gen;

    localparam int IFG = 12;
    localparam logic [111:0] HDR_REF =
        {48'hFFFFFFFFFFFF, 48'h000A35010203, 16'h88B5};

    logic clk = 1'b0;
    logic resetn0, resetn1;
    always #4 clk = ~clk;

    frame_gen_if bus0 ();
    frame_gen_if bus1 ();

    frame_gen dut0 (
        .clk125MHz (clk),
        .resetn    (resetn0),
        .fg        (bus0)
    );

    frame_gen #(.PAYLOAD_LEN(60)) dut1 (
        .clk125MHz (clk),
        .resetn    (resetn1),
        .fg        (bus1)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q [2][$];
    int         len_q [2][$];
    logic [7:0] rx_q  [2][$];
    int         run_len [2];
    logic       prev_en [2];
    bit         abort_f [2];
    bit         mon_on = 1'b0;
    logic       m_en;
    logic [7:0] m_d;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_raw(input logic [7:0] b[$],
                                            input int from);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = from; i < b.size(); i++) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++)
            r[i] = x[31-i];
        return r;
    endfunction

    function automatic void push_frame(input int k, input int plen,
        input logic [7:0] t, input logic [15:0] s, input logic [7:0] a);
        logic [7:0]   f[$];
        logic [111:0] h;
        logic [31:0]  fcs;
        f = {};
        for (int i = 0; i < 7; i++)
            f.push_back(8'h55);
        f.push_back(8'hD5);
        h = HDR_REF;
        for (int i = 0; i < 14; i++) begin
            f.push_back(h[111:104]);
            h = h << 8;
        end
        for (int i = 0; i < plen; i++) begin
            if (i == 0) f.push_back(t);
            else if (i == 1) f.push_back(s[15:8]);
            else if (i == 2) f.push_back(s[7:0]);
            else if (i == 3) f.push_back(a);
            else f.push_back(8'((i - 4) % 256));
        end
        fcs = ~crc_raw(f, 8);
        for (int i = 0; i < 4; i++) begin
            f.push_back(fcs[7:0]);
            fcs = fcs >> 8;
        end
        foreach (f[i])
            exp_q[k].push_back(f[i]);
        len_q[k].push_back(f.size());
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 2; k++) begin
                m_en = (k == 0) ? bus0.tx_en : bus1.tx_en;
                m_d  = (k == 0) ? bus0.txd : bus1.txd;
                if (m_en) begin
                    if (exp_q[k].size() == 0)
                        check($sformatf("dut%0d_unexpected_byte", k),
                              32'(m_d), 32'hFFFF_FFFF);
                    else
                        check($sformatf("dut%0d_byte%0d", k, run_len[k]),
                              32'(m_d), 32'(exp_q[k].pop_front()));
                    rx_q[k].push_back(m_d);
                    run_len[k]++;
                end else begin
                    check($sformatf("dut%0d_idle_txd", k), 32'(m_d), 32'h0);
                    if (prev_en[k]) begin
                        if (abort_f[k]) begin
                            exp_q[k].delete();
                            len_q[k].delete();
                            abort_f[k] = 1'b0;
                        end else begin
                            if (len_q[k].size() == 0)
                                check($sformatf("dut%0d_frame_len", k),
                                      32'(run_len[k]), 32'h0);
                            else
                                check($sformatf("dut%0d_frame_len", k),
                                      32'(run_len[k]),
                                      32'(len_q[k].pop_front()));
                            check($sformatf("dut%0d_fcs_residue", k),
                                  crc_raw(rx_q[k], 8),
                                  rev32(32'hC704DD7B));
                        end
                        rx_q[k].delete();
                        run_len[k] = 0;
                    end
                end
                prev_en[k] = m_en;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic st, input logic [7:0] t,
                         input logic [15:0] s, input logic [7:0] a);
        if (k == 0) begin
            bus0.start_sending = st;
            bus0.txid = t;
            bus0.segment_num = s;
            bus0.aux = a;
        end else begin
            bus1.start_sending = st;
            bus1.txid = t;
            bus1.segment_num = s;
            bus1.aux = a;
        end
    endtask

    function automatic logic busy_of(input int k);
        return (k == 0) ? bus0.busy : bus1.busy;
    endfunction

    function automatic logic en_of(input int k);
        return (k == 0) ? bus0.tx_en : bus1.tx_en;
    endfunction

    task automatic scramble(input int k);
        drive(k, 1'b0, 8'($urandom), 16'($urandom), 8'($urandom));
    endtask

    task automatic send(input int k, input int plen, input logic [7:0] t,
                        input logic [15:0] s, input logic [7:0] a);
        drive(k, 1'b1, t, s, a);
        push_frame(k, plen, t, s, a);
        tick();
        scramble(k);
        check("start_latency_busy", 32'(busy_of(k)), 32'h1);
        check("start_latency_tx_en", 32'(en_of(k)), 32'h1);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (busy_of(k) && n < 400) begin
            scramble(k);
            tick();
            n++;
        end
        check("wait_idle_timeout", 32'(busy_of(k)), 32'h0);
    endtask

    initial begin
        logic [7:0]  t, a;
        logic [15:0] s;
        int frames, low_run, busy_low, n;
        logic prev, en;

        resetn0 = 1'b0;
        resetn1 = 1'b0;
        drive(0, 1'b1, 8'h11, 16'h2222, 8'h33);
        drive(1, 1'b1, 8'h44, 16'h5555, 8'h66);
        repeat (3) tick();
        check("reset_busy0", 32'(bus0.busy), 32'h0);
        check("reset_tx_en0", 32'(bus0.tx_en), 32'h0);
        check("reset_txd0", 32'(bus0.txd), 32'h0);
        check("reset_busy1", 32'(bus1.busy), 32'h0);
        check("reset_tx_en1", 32'(bus1.tx_en), 32'h0);
        check("reset_txd1", 32'(bus1.txd), 32'h0);
        scramble(0);
        scramble(1);
        resetn0 = 1'b1;
        resetn1 = 1'b1;
        mon_on = 1'b1;
        tick();
        check("start_in_reset_ignored", 32'(bus0.busy), 32'h0);

        send(0, 46, 8'h5F, 16'h1234, 8'hA5);
        wait_idle(0);

        send(0, 46, 8'h00, 16'h0000, 8'h00);
        wait_idle(0);

        for (int i = 0; i < 4; i++) begin
            send(0, 46, 8'($urandom), 16'($urandom), 8'($urandom));
            wait_idle(0);
        end

        send(0, 46, 8'h5F, 16'h1234, 8'hA5);
        repeat (29) begin
            scramble(0);
            tick();
        end
        drive(0, 1'b1, 8'h5F, 16'hFFFF, 8'hA5);
        tick();
        scramble(0);
        wait_idle(0);
        repeat (30) tick();
        check("no_second_frame", 32'(bus0.busy), 32'h0);

        send(0, 46, 8'($urandom), 16'($urandom), 8'($urandom));
        repeat (39) tick();
        resetn0 = 1'b0;
        abort_f[0] = 1'b1;
        tick();
        check("abort_busy", 32'(bus0.busy), 32'h0);
        check("abort_tx_en", 32'(bus0.tx_en), 32'h0);
        check("abort_txd", 32'(bus0.txd), 32'h0);
        resetn0 = 1'b1;
        tick();
        send(0, 46, 8'h5F, 16'h1234, 8'hA5);
        wait_idle(0);

        t = 8'($urandom);
        s = 16'($urandom);
        a = 8'($urandom);
        for (int i = 0; i < 3; i++)
            push_frame(0, 46, t, s, a);
        drive(0, 1'b1, t, s, a);
        frames = 0;
        low_run = 0;
        busy_low = 0;
        n = 0;
        prev = 1'b0;
        while (frames < 3 && n < 1000) begin
            tick();
            n++;
            en = bus0.tx_en;
            if (en && !prev) begin
                frames++;
                if (frames > 1) begin
                    check("b2b_gap", 32'(low_run), 32'(IFG));
                    check("b2b_busy_low", 32'(busy_low), 32'h1);
                end
                if (frames == 3)
                    drive(0, 1'b0, t, s, a);
                low_run = 0;
                busy_low = 0;
            end else if (!en) begin
                low_run++;
            end
            if (!bus0.busy)
                busy_low++;
            prev = en;
        end
        check("b2b_frames", 32'(frames), 32'h3);
        wait_idle(0);

        send(1, 60, 8'($urandom), 16'($urandom), 8'($urandom));
        wait_idle(1);

        repeat (5) tick();
        check("leftover_dut0", 32'(exp_q[0].size()), 32'h0);
        check("leftover_dut1", 32'(exp_q[1].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_gen.md
FRAME_GEN -- requirements
Module: frame_gen

Interface
REQ-001 Parameter DST_MAC, 48'hFF_FF_FF_FF_FF_FF, destination MAC address.
REQ-002 Parameter SRC_MAC, 48'h00_0A_35_01_02_03, source MAC address.
REQ-003 Parameter ETHERTYPE, 16'h88B5, EtherType field value.
REQ-004 Parameter PAYLOAD_LEN, 46, payload byte count; legal range 46..1500.
REQ-005 Parameter IFG_LEN, 12, inter-frame gap in cycles.
REQ-006 clk125MHz  input  1  sole clock; all logic on its rising edge.
REQ-007 resetn  input  1  synchronous, active-low reset.
REQ-008 start_sending  input  1  single-cycle request to send one frame.
REQ-009 segment_num  input  16  segment number, sampled on an accepted start.
REQ-010 txid  input  8  transmitter ID, sampled on an accepted start.
REQ-011 aux  input  8  auxiliary tag, sampled on an accepted start.
REQ-012 busy  output  1  high from frame start through the end of the IFG.
REQ-013 tx_en  output  1  GMII transmit enable.
REQ-014 txd  output  8  GMII transmit data.

Function
REQ-015 States SHALL be IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, IFG, with one byte counter reused per state.
REQ-016 A start SHALL be accepted only when the block is in IDLE with start_sending high; start_sending in any other state SHALL be ignored.
REQ-017 On acceptance, segment_num/txid/aux SHALL be latched; busy, tx_en and the first preamble byte SHALL appear on the next cycle (latency 1).
REQ-018 PREAMBLE SHALL emit 7 x 8'h55 followed by 8'hD5 (SFD).
REQ-019 HEADER SHALL emit DST_MAC, then SRC_MAC, then ETHERTYPE, each MSB byte first (14 bytes).
REQ-020 PAYLOAD bytes 0..3 SHALL be txid, segment_num[15:8], segment_num[7:0], aux; bytes 4..PAYLOAD_LEN-1 SHALL be (index-4) mod 256.
REQ-021 CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF) SHALL cover the header and payload bytes only; FCS SHALL be the complemented CRC, least-significant byte first (4 bytes).
REQ-022 tx_en SHALL be high exactly 8+14+PAYLOAD_LEN+4 consecutive cycles per frame (72 at default).
REQ-023 IFG SHALL hold tx_en low and txd at 8'h00 for IFG_LEN cycles with busy high; busy SHALL drop on the cycle the block returns to IDLE.
REQ-024 A start asserted on the first IDLE cycle after IFG SHALL be accepted, so back-to-back frames are separated by exactly IFG_LEN idle tx_en cycles.
REQ-025 Latched fields SHALL NOT change mid-frame regardless of input activity.
REQ-026 txd SHALL be 8'h00 whenever tx_en is low.

Reset
REQ-027 With resetn low at a clock edge, state SHALL be IDLE and busy, tx_en, txd, counter and latched fields SHALL be 0 on the following cycle.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no FCS and no IFG; the next start after reset release SHALL produce a complete frame.
REQ-029 start_sending during reset SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the state encoding, PREAMBLE/SFD byte constants, header length (14), FCS length (4), and the CRC polynomial/init constants.
REQ-031 The byte-wide CRC-32 update SHALL be a separate sub-module, crc32_d8 (inputs: clock, resetn, init, enable, data byte; output: 32-bit CRC register).
REQ-032 Total RTL SHALL stay within 120-400 lines including crc32_d8.

Verification
REQ-033 Single frame, txid=8'h5F, segment_num=16'h1234, aux=8'hA5, defaults -> 72 tx_en cycles; payload bytes 0..4 = 5F 12 34 A5 00; CRC run over header+payload+FCS yields residue 32'hC704DD7B.
REQ-034 start_sending held high continuously from time 0 -> frames of 72 tx_en cycles separated by exactly 12 tx_en-low cycles; busy low for exactly 1 cycle between frames.
REQ-035 start_sending pulsed at tx_en cycle 30 with segment_num changed to 16'hFFFF -> ignored; frame still carries 12 34; no second frame.
REQ-036 resetn pulsed low at tx_en cycle 40 -> busy/tx_en/txd = 0 the next cycle; next start yields a clean 72-cycle frame with correct FCS.
REQ-037 PAYLOAD_LEN=60 -> 86 tx_en cycles; last payload byte = 8'h37; FCS residue check passes.
REQ-038 segment_num=16'h0000, txid=8'h00, aux=8'h00 -> payload bytes 0..3 all 8'h00, FCS residue check passes.
